// File: rtl/dm_resp.sv
// Data-memory responder: one load/store at a time, fixed wait states, then a
// registered response held until the requester takes it.
module dm_resp #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  if (WAIT_CYC > 15) begin : g_bad_wait
    $error("dm_resp: WAIT_CYC must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-3:0]   word_idx;
  logic                misaligned;
  logic                do_access;
  logic                mem_we;

  assign word_idx   = addr_q[ADDR_W-1:2];
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign mem_we     = do_access && wr_q && !misaligned;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    do_access   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d        = req_wr;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = 4'(WAIT_CYC);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Load data is the word as it stood before this edge's write.
          do_access   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = misaligned;
          rsp_rdata_d = (!wr_q && !misaligned) ? mem[word_idx] : 32'd0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage has no reset so a committed store survives a later reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two builds (WAIT_CYC=2 and 0) checked every cycle against
// a transaction-age model, plus directed scenarios with literal expectations.
module tb_dm_resp;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b0;
  logic            reqValid  [2];
  logic            reqReady  [2];
  logic            reqWr     [2];
  logic [AW-1:0]   reqAddr   [2];
  logic [31:0]     reqWdata  [2];
  logic [3:0]      reqBe     [2];
  logic            rspValid  [2];
  logic            rspReady  [2];
  logic [31:0]     rspRdata  [2];
  logic            rspErr    [2];

  dm_resp #(.ADDR_W(AW), .WAIT_CYC(2)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_wr(reqWr[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  dm_resp #(.ADDR_W(AW), .WAIT_CYC(0)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_wr(reqWr[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  int checks = 0;
  int failures = 0;
  bit checkOn = 0;

  int waitCyc [2] = '{2, 0};
  int wordSet [8] = '{0, 1, 4, 5, 8, 9, 'h200, 'h3FF};

  // Reference model: tracks edges elapsed since acceptance
  bit          mBusy  [2];
  int          mAge   [2];
  bit          mValid [2];
  bit          mReady [2];
  logic [31:0] mRdata [2];
  bit          mErr   [2];
  bit          cWr    [2];
  logic [AW-1:0] cAddr [2];
  logic [31:0] cWdata [2];
  logic [3:0]  cBe    [2];
  logic [31:0] mMem   [2][1024];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelAccess(input int k);
    int w;
    w = int'(cAddr[k]) / 4;
    mValid[k] = 1;
    if (cAddr[k] % 4 != 0) begin
      mErr[k] = 1;
      mRdata[k] = 0;
    end else if (cWr[k]) begin
      mErr[k] = 0;
      mRdata[k] = 0;
      for (int b = 0; b < 4; b++)
        if (cBe[k][b]) mMem[k][w][8*b +: 8] = cWdata[k][8*b +: 8];
    end else begin
      mErr[k] = 0;
      mRdata[k] = mMem[k][w];
    end
  endtask

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mBusy[k] = 0; mValid[k] = 0; mRdata[k] = 0; mErr[k] = 0; mReady[k] = 1;
      end else if (!mBusy[k]) begin
        if (reqValid[k]) begin
          cWr[k] = reqWr[k]; cAddr[k] = reqAddr[k];
          cWdata[k] = reqWdata[k]; cBe[k] = reqBe[k];
          mBusy[k] = 1; mAge[k] = 0; mReady[k] = 0;
        end
      end else if (!mValid[k]) begin
        mAge[k]++;
        if (mAge[k] == waitCyc[k] + 1) modelAccess(k);
      end else if (rspReady[k]) begin
        mValid[k] = 0; mRdata[k] = 0; mErr[k] = 0; mBusy[k] = 0; mReady[k] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("cyc%0d_req_ready", k), 32'(reqReady[k]), 32'(mReady[k]));
        checkOutput($sformatf("cyc%0d_rsp_valid", k), 32'(rspValid[k]), 32'(mValid[k]));
        checkOutput($sformatf("cyc%0d_rsp_rdata", k), rspRdata[k], mRdata[k]);
        checkOutput($sformatf("cyc%0d_rsp_err", k), 32'(rspErr[k]), 32'(mErr[k]));
      end
    end
  end

  task automatic applyStimulus(input int k, input bit wr, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int hold,
                               output logic [31:0] rdata, output logic err, output int lat);
    logic [31:0] heldData;
    logic heldErr;
    @(negedge clk); #1;
    reqValid[k] = 1; reqWr[k] = wr; reqAddr[k] = addr; reqWdata[k] = wdata; reqBe[k] = be;
    rspReady[k] = 0;
    @(posedge clk); #1;
    reqValid[k] = 0; reqWr[k] = ~wr; reqAddr[k] = AW'($urandom); reqWdata[k] = $urandom;
    reqBe[k] = 4'($urandom);
    checkOutput($sformatf("inst%0d_ready_drop", k), 32'(reqReady[k]), 32'd0);
    lat = 0;
    while (!rspValid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rspValid[k]) checkOutput($sformatf("inst%0d_rsp_timeout", k), 32'(rspValid[k]), 32'd1);
    rdata = rspRdata[k];
    err = rspErr[k];
    heldData = rspRdata[k];
    heldErr = rspErr[k];
    for (int i = 0; i < hold; i++) begin
      reqValid[k] = 1; reqAddr[k] = AW'($urandom);
      @(posedge clk); #1;
      checkOutput($sformatf("inst%0d_hold_valid", k), 32'(rspValid[k]), 32'd1);
      checkOutput($sformatf("inst%0d_hold_rdata", k), rspRdata[k], heldData);
      checkOutput($sformatf("inst%0d_hold_err", k), 32'(rspErr[k]), 32'(heldErr));
      checkOutput($sformatf("inst%0d_hold_noaccept", k), 32'(reqReady[k]), 32'd0);
    end
    reqValid[k] = 0;
    rspReady[k] = 1;
    @(posedge clk); #1;
    rspReady[k] = 0;
    checkOutput($sformatf("inst%0d_ready_back", k), 32'(reqReady[k]), 32'd1);
    checkOutput($sformatf("inst%0d_valid_clear", k), 32'(rspValid[k]), 32'd0);
  endtask

  function automatic logic [AW-1:0] randAddr();
    logic [9:0] w;
    logic [1:0] lo;
    w = 10'(wordSet[$urandom % 8]);
    lo = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
    return {w, lo};
  endfunction

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    int cnt;
    for (int k = 0; k < 2; k++) begin
      reqValid[k] = 0; reqWr[k] = 0; reqAddr[k] = '0; reqWdata[k] = 0; reqBe[k] = 0;
      rspReady[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1;
    checkOn = 1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset%0d_ready", k), 32'(reqReady[k]), 32'd1);
      checkOutput($sformatf("reset%0d_valid", k), 32'(rspValid[k]), 32'd0);
      checkOutput($sformatf("reset%0d_rdata", k), rspRdata[k], 32'd0);
    end

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++)
        applyStimulus(k, 1, AW'(wordSet[i] * 4), $urandom, 4'hF, 0, rd, er, lat);

    applyStimulus(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    checkOutput("t1_latency", 32'(lat), 32'd3);
    checkOutput("t1_rdata", rd, 32'd0);
    checkOutput("t1_err", 32'(er), 32'd0);

    applyStimulus(0, 1, 12'h010, 32'h11223344, 4'b0101, 0, rd, er, lat);
    applyStimulus(0, 0, 12'h010, 32'h0, 4'h0, 0, rd, er, lat);
    checkOutput("t2_merge", rd, 32'hDE22BE44);
    checkOutput("t2_model_mem", mMem[0][4], 32'hDE22BE44);

    applyStimulus(0, 0, 12'h010, 32'h0, 4'hF, 5, rd, er, lat);
    checkOutput("t3_backpressure_rdata", rd, 32'hDE22BE44);

    applyStimulus(0, 1, 12'h012, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    checkOutput("t4_err", 32'(er), 32'd1);
    checkOutput("t4_rdata", rd, 32'd0);
    applyStimulus(0, 0, 12'h010, 32'h0, 4'h0, 0, rd, er, lat);
    checkOutput("t4_unchanged", rd, 32'hDE22BE44);

    applyStimulus(0, 1, 12'h020, 32'h12345678, 4'hF, 0, rd, er, lat);
    @(negedge clk); #1;
    reqValid[0] = 1; reqWr[0] = 1; reqAddr[0] = 12'h020; reqWdata[0] = 32'hCAFEF00D; reqBe[0] = 4'hF;
    @(posedge clk); #1;
    reqValid[0] = 0;
    @(negedge clk); #1 rst = 0;
    @(negedge clk); #1 rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_no_response", 32'(rspValid[0]), 32'd0);
    end
    applyStimulus(0, 0, 12'h020, 32'h0, 4'h0, 0, rd, er, lat);
    checkOutput("t6_prior_value", rd, 32'h12345678);

    applyStimulus(1, 1, 12'h010, 32'hA5A55A5A, 4'hF, 0, rd, er, lat);
    applyStimulus(1, 0, 12'h010, 32'h0, 4'h0, 0, rd, er, lat);
    checkOutput("t5_latency", 32'(lat), 32'd1);
    checkOutput("t5_rdata", rd, 32'hA5A55A5A);

    @(negedge clk); #1;
    rspReady[1] = 1; reqValid[1] = 1; reqWr[1] = 0; reqAddr[1] = AW'(wordSet[$urandom % 8] * 4);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rspValid[1]) cnt++;
      #1 reqAddr[1] = AW'(wordSet[$urandom % 8] * 4);
    end
    reqValid[1] = 0;
    repeat (2) @(negedge clk);
    #1 rspReady[1] = 0;
    checkOutput("t5_back_to_back", 32'(cnt), 32'd10);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      rst = ($urandom % 250 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 2; k++) begin
        reqValid[k] = ($urandom % 3 == 0);
        reqWr[k] = 1'($urandom);
        reqAddr[k] = randAddr();
        reqWdata[k] = $urandom;
        reqBe[k] = 4'($urandom);
        rspReady[k] = 1'($urandom);
      end
    end
    @(negedge clk); #1;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      reqValid[k] = 0;
      rspReady[k] = 1;
    end
    repeat (6) @(negedge clk);
    checkOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
